// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed big-endian byte stream,
// writes it word by word and holds the CPU in reset until the image is complete.
module imem_loader #(
    parameter int unsigned ADDR_W    = 11,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        cpu_rst_no
);

    localparam logic [16:0] MaxLen = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        StIdle, StLenHi, StLenLo, StData, StDone, StErr
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       shift_q, shift_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [31:0]       wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              xfer;
    logic [15:0]       len_in;
    logic              last_word;

    assign xfer      = in_valid_i & in_ready_q;
    assign len_in    = {len_q[15:8], in_data_i};
    assign last_word = (16'(word_idx_q) == (len_q - 16'd1));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) state_d = StLenHi;
            end
            StLenHi: begin
                if (xfer) begin
                    len_d[15:8] = in_data_i;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d      = len_in;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    if (len_in == 16'd0) begin
                        state_d = StDone;
                    end else if ({1'b0, len_in} > MaxLen) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = {shift_q, in_data_i};
                        wr_addr_d  = BASE_ADDR + 32'({word_idx_q, 2'b00});
                        word_idx_d = word_idx_q + 1'b1;
                        if (last_word) state_d = StDone;
                    end else begin
                        shift_d = {shift_q[15:0], in_data_i};
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StLenHi) || (state_d == StLenLo) || (state_d == StData);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign in_ready_o = in_ready_q;
    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;
    assign busy_o     = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StData);
    assign done_o     = (state_q == StDone);
    assign error_o    = (state_q == StErr);
    assign cpu_rst_no = (state_q == StDone);

endmodule
